// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO for WIDTH-bit words with a registered read port.
//
// Ports:
//   clk_i    - clock; all state changes on the rising edge
//   rstn_i   - synchronous reset, active-high despite the name
//   wr_i     - write strobe; a word is accepted when the FIFO is not full
//   rd_i     - read strobe; a word is accepted when the FIFO is not empty
//   din_i    - write data, captured on the accepting edge
//   dout_o   - read data, updated on the accepting edge and held otherwise
//   empty_o  - FIFO holds no words (registered)
//   full_o   - FIFO holds DEPTH words (registered)
//
// The storage array has no reset, and its read port is registered, so it
// maps onto block RAM. The flags are registered from the next-state count.
// As a result, they never depend combinationally on the strobes.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             wr_i,
  input  logic             rd_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so that a count of DEPTH can be represented.
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [WIDTH-1:0] dout_reg;
  logic             empty_reg;
  logic             full_reg;

  logic             wr_en;
  logic             rd_en;

  // Acceptance uses only the registered flags. Because of this, a write to
  // a full FIFO is dropped even when a read is accepted in the same cycle.
  assign wr_en = wr_i & ~full_reg;
  assign rd_en = rd_i & ~empty_reg;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    // DEPTH is a power of two, so pointer overflow is the wrap to 0.
    if (wr_en) begin
      wr_ptr_next = wr_ptr_reg + 1'b1;
    end
    if (rd_en) begin
      rd_ptr_next = rd_ptr_reg + 1'b1;
    end
    case ({wr_en, rd_en})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  // Control state.
  always_ff @(posedge clk_i) begin
    if (rstn_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      empty_reg  <= 1'b1;
      full_reg   <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      empty_reg  <= (count_next == '0);
      full_reg   <= (count_next == CNT_W'(DEPTH));
    end
  end

  // Storage write port. There is no reset, because the contents are
  // meaningless after reset anyway.
  always_ff @(posedge clk_i) begin
    if (wr_en && !rstn_i) begin
      mem[wr_ptr_reg] <= din_i;
    end
  end

  // Registered read port. It is only updated by an accepted read, so a word
  // written into an empty FIFO is never bypassed to the output.
  always_ff @(posedge clk_i) begin
    if (rstn_i) begin
      dout_reg <= '0;
    end else if (rd_en) begin
      dout_reg <= mem[rd_ptr_reg];
    end
  end

  assign dout_o  = dout_reg;
  assign empty_o = empty_reg;
  assign full_o  = full_reg;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed testbench for sync_fifo (WIDTH=16, DEPTH=4).
module tb_sync_fifo;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        wr_i;
  logic        rd_i;
  logic [15:0] din_i;
  logic [15:0] dout_o;
  logic        empty_o;
  logic        full_o;

  int n_checks = 0;
  int n_fail   = 0;

  sync_fifo #(.WIDTH(16), .DEPTH(4)) dut (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .wr_i    (wr_i),
    .rd_i    (rd_i),
    .din_i   (din_i),
    .dout_o  (dout_o),
    .empty_o (empty_o),
    .full_o  (full_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of strobes. Return 1 time unit after the edge, with the strobes released.
  task automatic step(input logic wr, input logic rd, input logic [15:0] d);
    wr_i  = wr;
    rd_i  = rd;
    din_i = d;
    @(posedge clk_i);
    #1;
    wr_i  = 1'b0;
    rd_i  = 1'b0;
  endtask

  task automatic write_word(input logic [15:0] d);
    step(1'b1, 1'b0, d);
  endtask

  task automatic read_expect(input string tag, input logic [15:0] exp);
    step(1'b0, 1'b1, 16'h0000);
    check(tag, dout_o, exp);
    $display("read  %s dout=%h empty=%b full=%b", tag, dout_o, empty_o, full_o);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] fill [4];
    logic [15:0] wrapw [4];
    fill  = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    wrapw = '{16'hA0A0, 16'hA1A1, 16'hA2A2, 16'hA3A3};

    // Reset.
    rstn_i = 1'b1; wr_i = 1'b0; rd_i = 1'b0; din_i = 16'h0;
    @(posedge clk_i);
    #1;
    check("rst_dout", dout_o, 16'h0000);
    check("rst_empty", 16'(empty_o), 16'h1);
    check("rst_full", 16'(full_o), 16'h0);
    rstn_i = 1'b0;

    // Fill, then overflow.
    for (int i = 0; i < 4; i++) begin
      write_word(fill[i]);
      $display("write %h empty=%b full=%b", fill[i], empty_o, full_o);
      check("fill_empty", 16'(empty_o), 16'h0);
      check("fill_full", 16'(full_o), (i == 3) ? 16'h1 : 16'h0);
    end
    write_word(16'h5555);
    $display("write 5555 (overflow) full=%b", full_o);
    check("ovf_full", 16'(full_o), 16'h1);
    check("ovf_dout", dout_o, 16'h0000);

    // Drain, then underflow.
    for (int i = 0; i < 4; i++) begin
      read_expect("drain", fill[i]);
      check("drain_full", 16'(full_o), 16'h0);
      check("drain_empty", 16'(empty_o), (i == 3) ? 16'h1 : 16'h0);
    end
    read_expect("underflow_dout", 16'h4444);
    check("underflow_empty", 16'(empty_o), 16'h1);

    // Wrap-around.
    for (int i = 0; i < 3; i++) write_word(16'h0B01 + 16'(i));
    for (int i = 0; i < 3; i++) read_expect("pre_wrap", 16'h0B01 + 16'(i));
    check("pre_wrap_empty", 16'(empty_o), 16'h1);
    for (int i = 0; i < 4; i++) write_word(wrapw[i]);
    check("wrap_full", 16'(full_o), 16'h1);
    for (int i = 0; i < 4; i++) read_expect("wrap", wrapw[i]);
    check("wrap_empty", 16'(empty_o), 16'h1);

    // Simultaneous access with 2 words stored.
    write_word(16'hC001);
    write_word(16'hC002);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 16'hC003 + 16'(i));
      $display("wr+rd din=%h dout=%h empty=%b full=%b", 16'hC003 + 16'(i), dout_o, empty_o, full_o);
      check("simul_dout", dout_o, 16'hC001 + 16'(i));
      check("simul_empty", 16'(empty_o), 16'h0);
      check("simul_full", 16'(full_o), 16'h0);
    end
    read_expect("simul_drain", 16'hC004);
    check("simul_cnt1", 16'(empty_o), 16'h0);
    read_expect("simul_drain", 16'hC005);
    check("simul_cnt0", 16'(empty_o), 16'h1);

    // Simultaneous access on an empty FIFO: the word is written, but it is not bypassed.
    step(1'b1, 1'b1, 16'hD00D);
    $display("wr+rd on empty dout=%h empty=%b", dout_o, empty_o);
    check("empty_simul_dout", dout_o, 16'hC005);
    check("empty_simul_empty", 16'(empty_o), 16'h0);
    read_expect("empty_simul_read", 16'hD00D);
    check("empty_simul_after", 16'(empty_o), 16'h1);

    // Simultaneous access on a full FIFO: only the read is performed.
    for (int i = 0; i < 4; i++) write_word(16'h7700 + 16'(i));
    step(1'b1, 1'b1, 16'h77FF);
    $display("wr+rd on full dout=%h full=%b", dout_o, full_o);
    check("full_simul_dout", dout_o, 16'h7700);
    check("full_simul_full", 16'(full_o), 16'h0);
    for (int i = 1; i < 4; i++) read_expect("full_simul_drain", 16'h7700 + 16'(i));
    check("full_simul_empty", 16'(empty_o), 16'h1);

    // Reset mid-operation.
    for (int i = 0; i < 3; i++) write_word(16'hE001 + 16'(i));
    rstn_i = 1'b1;
    @(posedge clk_i);
    #1;
    rstn_i = 1'b0;
    $display("mid reset dout=%h empty=%b full=%b", dout_o, empty_o, full_o);
    check("midrst_empty", 16'(empty_o), 16'h1);
    check("midrst_dout", dout_o, 16'h0000);
    check("midrst_full", 16'(full_o), 16'h0);
    read_expect("midrst_read_ignored", 16'h0000);
    check("midrst_read_empty", 16'(empty_o), 16'h1);
    write_word(16'hF00F);
    read_expect("post_rst", 16'hF00F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
